// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// fpu_issue_ctrl : FP issue/sequencing stage ahead of F_CVT and the div/sqrt unit
// Revision 1.0
// ============================================================================
module fpu_issue_ctrl #(
  parameter int FLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [6:0]      Funct7,
  input  logic [4:0]      Rs2_Field,
  input  logic [4:0]      Rd,
  input  logic [FLEN-1:0] Rs1_Data,
  input  logic [FLEN-1:0] Rs2_Data,
  output logic            Cvt_En,
  output logic            Cvt_Rs2_0,
  output logic            Cvt_Funct7_3,
  output logic [FLEN-1:0] Cvt_Rs1,
  input  logic [FLEN-1:0] Cvt_Result,
  output logic            Div_Start,
  output logic            Div_Op,
  output logic [FLEN-1:0] Div_A,
  output logic [FLEN-1:0] Div_B,
  input  logic            Div_Done,
  input  logic [FLEN-1:0] Div_Result,
  output logic            Wb_Valid,
  input  logic            Wb_Ready,
  output logic [4:0]      Wb_Rd,
  output logic            Wb_To_Int,
  output logic [FLEN-1:0] Wb_Data,
  output logic            Wb_Err
);

  localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
  localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
  localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
  localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;
  localparam logic [6:0] F7_FDIV     = 7'b0001100;
  localparam logic [6:0] F7_FSQRT    = 7'b0101100;

  localparam logic [FLEN-1:0] CANON_NAN = FLEN'(32'h7FC00000);
  localparam logic [7:0]      CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_WB       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_CVT     = 2'd0,
    C_MOVE    = 2'd1,
    C_DIV     = 2'd2,
    C_ILLEGAL = 2'd3
  } cls_t;

  state_t          state;
  cls_t            dec_cls;
  logic            dec_to_int;
  logic [7:0]      cnt;
  logic [FLEN-1:0] rs1_q;
  logic [FLEN-1:0] rs2_q;
  logic [4:0]      rd_q;
  logic            rs2_0_q;
  logic            f7_3_q;
  logic            to_int_q;
  logic            div_op_q;
  logic            ready_q;
  logic            cvt_en_q;
  logic            div_start_q;
  logic            wb_valid_q;
  logic            wb_err_q;
  logic [FLEN-1:0] wb_data_q;
  logic            unused_rs2_hi;

  assign unused_rs2_hi = ^Rs2_Field[4:1];

  always_comb begin
    dec_cls    = C_ILLEGAL;
    dec_to_int = 1'b0;
    case (Funct7)
      F7_FCVT_W_S: begin dec_cls = C_CVT;  dec_to_int = 1'b1; end
      F7_FCVT_S_W: begin dec_cls = C_CVT;  dec_to_int = 1'b0; end
      F7_FMV_X_W:  begin dec_cls = C_MOVE; dec_to_int = 1'b1; end
      F7_FMV_W_X:  begin dec_cls = C_MOVE; dec_to_int = 1'b0; end
      F7_FDIV:     dec_cls = C_DIV;
      F7_FSQRT:    dec_cls = C_DIV;
      default:     dec_cls = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs2_0_q     <= 1'b0;
      f7_3_q      <= 1'b0;
      to_int_q    <= 1'b0;
      div_op_q    <= 1'b0;
      ready_q     <= 1'b1;
      cvt_en_q    <= 1'b0;
      div_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (In_Valid) begin
            rs1_q    <= Rs1_Data;
            rs2_q    <= Rs2_Data;
            rd_q     <= Rd;
            rs2_0_q  <= Rs2_Field[0];
            f7_3_q   <= Funct7[3];
            to_int_q <= dec_to_int;
            div_op_q <= (Funct7 == F7_FSQRT);
            ready_q  <= 1'b0;
            case (dec_cls)
              C_MOVE: begin
                wb_data_q  <= Rs1_Data;
                wb_err_q   <= 1'b0;
                wb_valid_q <= 1'b1;
                state      <= S_WB;
              end
              C_CVT: begin
                cvt_en_q <= 1'b1;
                state    <= S_EXEC;
              end
              C_DIV: begin
                div_start_q <= 1'b1;
                cnt         <= '0;
                state       <= S_DIV_WAIT;
              end
              default: begin
                wb_data_q  <= '0;
                wb_err_q   <= 1'b1;
                wb_valid_q <= 1'b1;
                state      <= S_WB;
              end
            endcase
          end
        end
        S_EXEC: begin
          cvt_en_q   <= 1'b0;
          wb_data_q  <= Cvt_Result;
          wb_err_q   <= 1'b0;
          wb_valid_q <= 1'b1;
          state      <= S_WB;
        end
        S_DIV_WAIT: begin
          div_start_q <= 1'b0;
          // Done wins over timeout, even on the start cycle.
          if (Div_Done) begin
            wb_data_q  <= Div_Result;
            wb_err_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            state      <= S_WB;
          end else if (cnt == CNT_LAST) begin
            wb_data_q  <= CANON_NAN;
            wb_err_q   <= 1'b1;
            wb_valid_q <= 1'b1;
            state      <= S_WB;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WB: begin
          if (Wb_Ready) begin
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign In_Ready     = ready_q;
  assign Cvt_En       = cvt_en_q;
  assign Cvt_Rs2_0    = rs2_0_q;
  assign Cvt_Funct7_3 = f7_3_q;
  assign Cvt_Rs1      = rs1_q;
  assign Div_Start    = div_start_q;
  assign Div_Op       = div_op_q;
  assign Div_A        = rs1_q;
  assign Div_B        = rs2_q;
  assign Wb_Valid     = wb_valid_q;
  assign Wb_Rd        = rd_q;
  assign Wb_To_Int    = to_int_q;
  assign Wb_Data      = wb_data_q;
  assign Wb_Err       = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fpu_issue_ctrl : scoreboard bench for fpu_issue_ctrl with directed vectors
// Revision 1.0
// ============================================================================
module tb_fpu_issue_ctrl;

  logic        CLK, RST, In_Valid, In_Ready;
  logic [6:0]  Funct7;
  logic [4:0]  Rs2_Field, Rd;
  logic [31:0] Rs1_Data, Rs2_Data;
  logic        Cvt_En, Cvt_Rs2_0, Cvt_Funct7_3;
  logic [31:0] Cvt_Rs1, Cvt_Result;
  logic        Div_Start, Div_Op;
  logic [31:0] Div_A, Div_B;
  logic        Div_Done;
  logic [31:0] Div_Result;
  logic        Wb_Valid, Wb_Ready, Wb_To_Int, Wb_Err;
  logic [4:0]  Wb_Rd;
  logic [31:0] Wb_Data;

  fpu_issue_ctrl #(.FLEN(32), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Funct7(Funct7), .Rs2_Field(Rs2_Field), .Rd(Rd),
    .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Cvt_En(Cvt_En), .Cvt_Rs2_0(Cvt_Rs2_0), .Cvt_Funct7_3(Cvt_Funct7_3),
    .Cvt_Rs1(Cvt_Rs1), .Cvt_Result(Cvt_Result),
    .Div_Start(Div_Start), .Div_Op(Div_Op), .Div_A(Div_A), .Div_B(Div_B),
    .Div_Done(Div_Done), .Div_Result(Div_Result),
    .Wb_Valid(Wb_Valid), .Wb_Ready(Wb_Ready), .Wb_Rd(Wb_Rd),
    .Wb_To_Int(Wb_To_Int), .Wb_Data(Wb_Data), .Wb_Err(Wb_Err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        to_int;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   div_starts = 0;
  int   cvt_ens = 0;
  bit   in_wb = 0;
  int   first_cyc = 0;
  logic [38:0] held;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Small converter model: only valid while Cvt_En, poison otherwise.
  always_comb begin
    Cvt_Result = 32'hBAD0BAD0;
    if (Cvt_En) begin
      if (Cvt_Funct7_3 && Cvt_Rs1 == 32'd5)              Cvt_Result = 32'h40A00000;
      else if (Cvt_Funct7_3 && Cvt_Rs1 == 32'd3)         Cvt_Result = 32'h40400000;
      else if (!Cvt_Funct7_3 && Cvt_Rs1 == 32'h40A00000) Cvt_Result = 32'd5;
      else if (!Cvt_Funct7_3 && Cvt_Rs1 == 32'h40400000) Cvt_Result = 32'd3;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [4:0] rd, input logic to_int, input logic err,
                      input logic [31:0] data, input int c);
    exp_t e;
    e.rd = rd; e.to_int = to_int; e.err = err; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Returns e such that cycle k after the accept edge has cyc == e + k.
  task automatic issue(input logic [6:0] f7, input logic [4:0] r2f, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, output int e);
    Funct7 = f7; Rs2_Field = r2f; Rd = rd; Rs1_Data = a; Rs2_Data = b;
    In_Valid = 1'b1;
    @(posedge CLK); #1;
    e = cyc - 1;
    In_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((!In_Ready || exp_q.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_completes"}, 64'(n < 300), 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_ctl"}, 64'({In_Ready, Cvt_En, Div_Start, Wb_Valid, Wb_Err, Wb_To_Int,
                            Div_Op, Cvt_Rs2_0, Cvt_Funct7_3}), 64'(9'b100000000));
    chk({pfx, "_wbdata_cvtrs1"}, {Wb_Data, Cvt_Rs1}, 64'd0);
    chk({pfx, "_div_ab"}, {Div_A, Div_B}, 64'd0);
    chk({pfx, "_wbrd"}, 64'(Wb_Rd), 64'd0);
  endtask

  always @(negedge CLK) begin
    if (Div_Start) div_starts++;
    if (Cvt_En) cvt_ens++;
  end

  // Scoreboard monitor: compare each writeback beat at its handshake.
  always @(negedge CLK) begin
    if (RST || !Wb_Valid) begin
      in_wb = 1'b0;
    end else begin
      if (!in_wb) begin
        in_wb = 1'b1;
        first_cyc = cyc;
        held = {Wb_Rd, Wb_To_Int, Wb_Err, Wb_Data};
      end else begin
        chk("wb_hold", 64'({Wb_Rd, Wb_To_Int, Wb_Err, Wb_Data}), 64'(held));
      end
      if (Wb_Ready) begin
        in_wb = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 64'(Wb_Valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_data", 64'(Wb_Data), 64'(e.data));
          chk("wb_rd", 64'(Wb_Rd), 64'(e.rd));
          chk("wb_to_int", 64'(Wb_To_Int), 64'(e.to_int));
          chk("wb_err", 64'(Wb_Err), 64'(e.err));
          chk("wb_cycle", 64'(first_cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int e, s0;
    RST = 1'b1; In_Valid = 1'b0; Funct7 = '0; Rs2_Field = '0; Rd = '0;
    Rs1_Data = '0; Rs2_Data = '0; Div_Done = 1'b0; Div_Result = '0; Wb_Ready = 1'b1;
    #3;
    reset_checks("rst");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // FCVT.S.W 5 -> 5.0
    s0 = cvt_ens;
    issue(7'b1101000, 5'd0, 5'd3, 32'd5, 32'd0, e);
    push(5'd3, 1'b0, 1'b0, 32'h40A00000, e + 2);
    @(negedge CLK);
    chk("cvt_en_c1", 64'(Cvt_En), 64'd1);
    chk("cvt_f7_3", 64'(Cvt_Funct7_3), 64'd1);
    chk("in_ready_c1", 64'(In_Ready), 64'd0);
    @(negedge CLK);
    chk("cvt_en_c2", 64'(Cvt_En), 64'd0);
    wait_idle("fcvt_s_w");
    chk("cvt_en_cycles", 64'(cvt_ens - s0), 64'd1);

    // FCVT.W.S 5.0 -> 5, rd 7, ready again in cycle 3
    issue(7'b1100000, 5'd0, 5'd7, 32'h40A00000, 32'd0, e);
    push(5'd7, 1'b1, 1'b0, 32'd5, e + 2);
    @(negedge CLK); @(negedge CLK);
    chk("in_ready_c2", 64'(In_Ready), 64'd0);
    @(negedge CLK);
    chk("in_ready_c3", 64'(In_Ready), 64'd1);
    wait_idle("fcvt_w_s");

    // FCVT.WU.S 3.0 -> 3, unsigned bit forwarded
    issue(7'b1100000, 5'd1, 5'd9, 32'h40400000, 32'd0, e);
    push(5'd9, 1'b1, 1'b0, 32'd3, e + 2);
    @(negedge CLK);
    chk("cvt_rs2_0", 64'(Cvt_Rs2_0), 64'd1);
    wait_idle("fcvt_wu_s");

    // FMV.X.W with writeback stalled for cycles 1-3, competing offer ignored
    Wb_Ready = 1'b0;
    issue(7'b1110000, 5'd0, 5'd4, 32'hDEADBEEF, 32'd0, e);
    push(5'd4, 1'b1, 1'b0, 32'hDEADBEEF, e + 1);
    Funct7 = 7'b0000000; Rd = 5'd30; Rs1_Data = 32'h12345678; In_Valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk("fmv_stall_valid", 64'(Wb_Valid), 64'd1);
      chk("fmv_stall_data", 64'(Wb_Data), 64'hDEADBEEF);
      chk("fmv_stall_ready", 64'(In_Ready), 64'd0);
    end
    @(posedge CLK); #1;
    Wb_Ready = 1'b1; In_Valid = 1'b0;
    @(negedge CLK);
    chk("fmv_c4_valid", 64'(Wb_Valid), 64'd1);
    wait_idle("fmv_x_w");

    // FDIV 10/2, done in cycle 10
    s0 = div_starts;
    issue(7'b0001100, 5'd0, 5'd11, 32'h41200000, 32'h40000000, e);
    push(5'd11, 1'b0, 1'b0, 32'h40A00000, e + 11);
    @(negedge CLK);
    chk("div_start_c1", 64'(Div_Start), 64'd1);
    chk("div_op_fdiv", 64'(Div_Op), 64'd0);
    chk("div_ab", {Div_A, Div_B}, {32'h41200000, 32'h40000000});
    repeat (9) begin @(posedge CLK); #1; end
    Div_Done = 1'b1; Div_Result = 32'h40A00000;
    @(posedge CLK); #1;
    Div_Done = 1'b0; Div_Result = '0;
    wait_idle("fdiv");
    chk("div_start_pulses", 64'(div_starts - s0), 64'd1);

    // FDIV with done on the start cycle
    issue(7'b0001100, 5'd0, 5'd12, 32'h40000000, 32'h40000000, e);
    Div_Done = 1'b1; Div_Result = 32'h3F800000;
    push(5'd12, 1'b0, 1'b0, 32'h3F800000, e + 2);
    @(posedge CLK); #1;
    Div_Done = 1'b0; Div_Result = '0;
    wait_idle("fdiv_fast");

    // FSQRT timeout
    issue(7'b0101100, 5'd0, 5'd13, 32'h40800000, 32'd0, e);
    push(5'd13, 1'b0, 1'b1, 32'h7FC00000, e + 65);
    @(negedge CLK);
    chk("div_op_fsqrt", 64'(Div_Op), 64'd1);
    wait_idle("fsqrt_timeout");

    // Illegal funct7
    issue(7'b0000000, 5'd0, 5'd14, 32'hCAFEF00D, 32'd1, e);
    push(5'd14, 1'b0, 1'b1, 32'd0, e + 1);
    wait_idle("illegal");

    // Reset in cycle 4 of an FDIV, late Div_Done ignored
    issue(7'b0001100, 5'd0, 5'd15, 32'h41200000, 32'h40000000, e);
    repeat (3) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    Div_Done = 1'b1; Div_Result = 32'h11111111;
    @(negedge CLK);
    chk("late_done_c6_valid", 64'(Wb_Valid), 64'd0);
    @(posedge CLK); #1;
    Div_Done = 1'b0; Div_Result = '0;
    @(negedge CLK);
    chk("late_done_c7_valid", 64'(Wb_Valid), 64'd0);
    chk("late_done_ready", 64'(In_Ready), 64'd1);
    @(posedge CLK); #1;

    // FMV.W.X after the abort
    issue(7'b1111000, 5'd0, 5'd0, 32'h3F800000, 32'd0, e);
    push(5'd0, 1'b0, 1'b0, 32'h3F800000, e + 1);
    wait_idle("fmv_w_x");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Sequencing stage directly upstream of the F_CVT converter in the floating ALU. It accepts one decoded FP instruction at a time from the core through a valid/ready handshake, registers the operands, and drives the converter's `En`/`Rs1`/`Rs2_0`/`Funct7_3` inputs. It also executes FMV moves internally and runs a start/done handshake with the external multi-cycle divide/sqrt unit, guarded by a timeout. Every instruction ends in exactly one writeback beat, held until the core accepts it, tagged for either the integer or the FP register file.

## Interface
Parameters
- FLEN, 32, operand/result width
- TIMEOUT, 64, maximum DIV_WAIT cycles before forced completion (2..255)

Ports
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- In_Valid  in  1  instruction offered
- In_Ready  out  1  block can accept
- Funct7  in  7  instruction funct7
- Rs2_Field  in  5  instruction rs2 field
- Rd  in  5  destination register index
- Rs1_Data  in  FLEN  first operand (int or FP, selected by core)
- Rs2_Data  in  FLEN  second operand
- Cvt_En, Cvt_Rs2_0, Cvt_Funct7_3  out  1 each  to F_CVT
- Cvt_Rs1  out  FLEN  to F_CVT
- Cvt_Result  in  FLEN  from F_CVT (combinational)
- Div_Start  out  1  one-cycle start pulse
- Div_Op  out  1  0 = FDIV, 1 = FSQRT
- Div_A, Div_B  out  FLEN  held operands
- Div_Done  in  1  result valid
- Div_Result  in  FLEN  divide/sqrt result
- Wb_Valid  out  1  writeback beat present
- Wb_Ready  in  1  core accepts writeback
- Wb_Rd  out  5  destination index
- Wb_To_Int  out  1  1 = integer regfile, 0 = FP regfile
- Wb_Data  out  FLEN  result
- Wb_Err  out  1  illegal op or timeout

## Operation
Decode on Funct7 at accept:
- 1100000 FCVT.W[U].S: CVT class, To_Int = 1
- 1101000 FCVT.S.W[U]: CVT class, To_Int = 0
- 1110000 FMV.X.W: MOVE class, To_Int = 1
- 1111000 FMV.W.X: MOVE class, To_Int = 0
- 0001100 FDIV.S: DIV class, Div_Op = 0
- 0101100 FSQRT.S: DIV class, Div_Op = 1
- Any other value: ILLEGAL class.

Accept and operand registers:
- Accept occurs when In_Valid && In_Ready.
- At accept, register Rs1_Data, Rs2_Data, Rd, Rs2_Field[0], Funct7[3], class and To_Int.
- The operand registers drive Cvt_Rs1, Div_A and Div_B at all times.
- Cvt_Rs2_0 and Cvt_Funct7_3 come from the registered bits.

FSM states: IDLE, EXEC, DIV_WAIT, WB.
- IDLE: In_Ready = 1. On accept:
  - MOVE: go to WB with Wb_Data = Rs1_Data.
  - ILLEGAL: go to WB with Wb_Data = 0, Wb_Err = 1, Wb_To_Int = 0.
  - CVT: go to EXEC.
  - DIV: go to DIV_WAIT and clear the counter.
- EXEC: Cvt_En = 1 for exactly this cycle. Capture Cvt_Result into Wb_Data, then go to WB.
- DIV_WAIT:
  - Div_Start = 1 only in the first cycle in this state.
  - If Div_Done = 1 (including the start cycle), capture Div_Result with Wb_Err = 0 and go to WB.
  - Otherwise, when the counter reaches TIMEOUT-1, go to WB with Wb_Data = 32'h7FC00000 and Wb_Err = 1.
  - Otherwise, increment the counter.
- WB: Wb_Valid = 1 and all Wb_* outputs are held stable. When Wb_Ready = 1, go to IDLE.

Other rules:
- Div_Done is ignored outside DIV_WAIT.
- Cvt_En = 0 outside EXEC.
- Rd = 0 is written back unchanged; the regfile discards it.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE, In_Ready = 1. Every other output is 0: Cvt_En, Div_Start, Wb_Valid, Wb_Err, Wb_To_Int, Div_Op, Wb_Rd, Wb_Data, Cvt_Rs1, Cvt_Rs2_0, Cvt_Funct7_3, Div_A, Div_B. Counter = 0.
- Latency, counting the accept edge as edge 0:
  - MOVE/ILLEGAL: Wb_Valid in cycle 1.
  - CVT: Cvt_En in cycle 1, Wb_Valid in cycle 2.
  - DIV: Div_Start in cycle 1. Done seen in cycle 1+k gives Wb_Valid in cycle 2+k. Timeout gives Wb_Valid in cycle 1+TIMEOUT.
- No overlap: In_Ready = 0 from the cycle after accept until the cycle after the WB handshake. There is no same-cycle bypass from WB to IDLE.
- Wb_Ready low holds WB indefinitely.
- Reset asserted mid-operation aborts the instruction. Div_Start drops immediately, and a later Div_Done arriving in IDLE is ignored.

## Test plan
- FCVT.S.W, Funct7 = 1101000, Rs2_Field = 0, Rs1_Data = 32'd5, Wb_Ready = 1 -> Cvt_En only in cycle 1; Wb_Valid in cycle 2 with Wb_Data = 32'h40A00000, Wb_To_Int = 0, Wb_Err = 0.
- FCVT.W.S, Funct7 = 1100000, Rs1_Data = 32'h40A00000, Rd = 7 -> cycle 2: Wb_Data = 5, Wb_To_Int = 1, Wb_Rd = 7; In_Ready = 1 again in cycle 3.
- FMV.X.W, Rs1_Data = 32'hDEADBEEF, Wb_Ready low for cycles 1-3 -> Wb_Valid asserted in cycles 1-4 with data stable at 32'hDEADBEEF and Wb_To_Int = 1; In_Ready = 0 throughout and In_Valid ignored.
- FDIV, A = 32'h41200000, B = 32'h40000000, Div_Done with Div_Result = 32'h40A00000 in cycle 10 -> single Div_Start pulse in cycle 1; Wb_Valid in cycle 11 with Wb_Data = 32'h40A00000.
- FSQRT with Div_Done never asserted, TIMEOUT = 64 -> Div_Op = 1; Wb_Valid in cycle 65 with Wb_Data = 32'h7FC00000, Wb_Err = 1. Funct7 = 0000000 -> Wb_Err = 1 in cycle 1.
- RST pulsed in cycle 4 of an FDIV -> all outputs at reset values immediately; a Div_Done arriving in cycle 6 produces no Wb_Valid; the next FMV executes normally.
